sort_stream_ctrl: RTL and testbench
===================================

# sort_stream_ctrl

Stream-side controller for the 8-entry selection sorter. It collects eight bytes from an upstream valid/ready stream and writes them into the sorter's memory through its addr/wr/datain port. It then pulses the sorter's start and waits for its ready to return. Finally it reads the sorted bytes back in address order and emits them on a downstream valid/ready stream with a last marker.

## Interface
- W, 8, data width; must match sorter memory width
- AW, 3, sorter address width; DEPTH = 2**AW = 8 entries
- TIMEOUT, 256, max cycles in WAITHI before abort

- clk  in  1  clock, all state on rising edge
- nrst  in  1  reset, asynchronous, active-low
- in_valid  in  1  upstream data valid
- in_data  in  W  upstream byte
- in_ready  out  1  upstream accept
- out_valid  out  1  sorted byte valid
- out_data  out  W  sorted byte
- out_ready  in  1  downstream accept
- out_last  out  1  high with the final (DEPTH-th) element
- srt_start  out  1  sorter start pulse
- srt_wr  out  1  sorter write enable
- srt_addr  out  AW  sorter address (write and read)
- srt_datain  out  W  sorter write data
- srt_dataout  in  W  sorter read data, registered, 1-cycle read latency
- srt_ready  in  1  sorter idle flag
- done  out  1  one-cycle pulse after last element handshaked
- err  out  1  one-cycle pulse on sorter timeout

## Operation
- Element counter cnt[AW-1:0] and wait timer tmr (clog2(TIMEOUT+1) bits).
- States: LOAD, KICK, WAITLO, WAITHI, RDREQ, RDCAP, PRESENT.
- LOAD:
  - in_ready = srt_ready (combinational).
  - Transfer = in_valid & in_ready; it drives srt_wr=1, srt_addr=cnt, srt_datain=in_data combinationally in the same cycle.
  - Each transfer does cnt++.
  - Transfer with cnt==DEPTH-1 sets cnt←0 and moves to KICK.
- KICK: srt_start=1 for exactly one cycle -> WAITLO.
- WAITLO: one dead cycle while the sorter drops ready; srt_ready ignored -> WAITHI; tmr←0.
- WAITHI:
  - srt_ready=1 -> RDREQ.
  - Else tmr++. When tmr==TIMEOUT-1 with srt_ready still 0: err pulses next cycle, cnt←0, -> LOAD.
- RDREQ: srt_addr=cnt, srt_wr=0 (sorter registers read) -> RDCAP.
- RDCAP: srt_dataout is valid; out_data←srt_dataout, out_valid←1 -> PRESENT.
- PRESENT:
  - Hold out_data/out_valid stable until out_ready.
  - On handshake out_valid←0.
  - If cnt==DEPTH-1: cnt←0, done pulses, -> LOAD.
  - Else cnt++, -> RDREQ.
- out_last = out_valid & (cnt==DEPTH-1).
- In every state except LOAD: srt_addr=cnt, srt_wr=0, srt_datain=0, in_ready=0.
- No arithmetic on data; bytes pass unmodified. cnt wraps only via explicit reset to 0, never by overflow.

## Timing
- Reset values: state=LOAD, cnt=0, tmr=0, out_valid=0, out_data=0, out_last=0, srt_start=0, srt_wr=0, srt_addr=0, srt_datain=0, done=0, err=0. in_ready follows srt_ready.
- nrst assertion mid-operation: immediate return to reset values regardless of state. Partially loaded data is discarded logically; it is not erased from the sorter.
- Accept rate in LOAD: 1 byte/cycle.
- Latency:
  - 8th accept edge -> srt_start high during the following cycle.
  - Edge sampling srt_ready=1 in WAITHI -> out_valid high two edges later.
- Drain with out_ready held 1: one element every 3 cycles; 24 cycles for 8 elements.
- out_valid never drops without a handshake; out_data changes only in RDCAP.
- done and err are mutually exclusive, one cycle each, registered.
- in_valid asserted outside LOAD: ignored, no write.

## Test plan
- Load 8'h37,05,F0,12,05,A0,01,7E with in_valid held 1 -> 8 consecutive srt_wr pulses at addr 0..7, then one-cycle srt_start.
- Behavioural sorter finishes 60 cycles after start, out_ready=1 -> out stream 01,05,05,12,37,7E,A0,F0; out_last only on F0; done pulses once; 3 cycles per element.
- Same data, out_ready toggled 1-0-0-1 randomly -> identical sequence; out_data stable while out_valid & !out_ready; no loss or duplication.
- Sorter model never raises srt_ready, TIMEOUT=16 -> err pulses 17 cycles after WAITHI entry; state returns to LOAD; out_valid never asserts.
- nrst pulsed low after 5 loaded bytes, then 8 fresh bytes loaded -> first write after reset at addr 0; output is the sorted fresh 8 bytes.
- srt_ready=0 in LOAD with in_valid=1 -> in_ready=0, no srt_wr; accepting resumes the cycle srt_ready returns.

Source files
------------

// File: rtl/sort_stream_ctrl.sv
// sort_stream_ctrl: loads DEPTH stream bytes into the sorter, kicks it, waits (with timeout), then streams the sorted bytes out with last/done/err
module sort_stream_ctrl #(
  parameter int W = 8,
  parameter int AW = 3,
  parameter int TIMEOUT = 256
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  input  logic          out_ready,
  output logic          out_last,
  output logic          srt_start,
  output logic          srt_wr,
  output logic [AW-1:0] srt_addr,
  output logic [W-1:0]  srt_datain,
  input  logic [W-1:0]  srt_dataout,
  input  logic          srt_ready,
  output logic          done,
  output logic          err
);
  localparam int DEPTH = 2**AW;
  localparam int TW = $clog2(TIMEOUT+1);
  typedef enum logic [2:0] {LOAD, KICK, WAITLO, WAITHI, RDREQ, RDCAP, PRESENT} state_t;
  state_t state;
  logic [AW-1:0] cnt;
  logic [TW-1:0] tmr;
  logic xfer, last;
  always_comb begin
    in_ready = (state == LOAD) & srt_ready;
    xfer = in_ready & in_valid;
    srt_wr = xfer;
    srt_addr = cnt;
    srt_datain = xfer ? in_data : '0;
    last = cnt == AW'(DEPTH-1);
    out_last = out_valid & last;
  end
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      state <= LOAD;
      cnt <= '0;
      tmr <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
      srt_start <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      srt_start <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      case (state)
        LOAD: if (xfer) begin
          cnt <= last ? '0 : cnt + AW'(1);
          state <= last ? KICK : LOAD;
          srt_start <= last;
        end
        KICK: state <= WAITLO;
        WAITLO: begin
          tmr <= '0;
          state <= WAITHI;
        end
        WAITHI: if (srt_ready) state <= RDREQ;
        else if (tmr == TW'(TIMEOUT-1)) begin
          err <= 1'b1;
          cnt <= '0;
          state <= LOAD;
        end else tmr <= tmr + TW'(1);
        RDREQ: state <= RDCAP;
        RDCAP: begin
          out_data <= srt_dataout;
          out_valid <= 1'b1;
          state <= PRESENT;
        end
        PRESENT: if (out_ready) begin
          out_valid <= 1'b0;
          cnt <= last ? '0 : cnt + AW'(1);
          done <= last;
          state <= last ? LOAD : RDREQ;
        end
        default: state <= LOAD;
      endcase
    end
endmodule

// File: tb/tb_sort_stream_ctrl.sv
// tb_sort_stream_ctrl: directed self-checking bench with a behavioural 8-entry sorter
module tb_sort_stream_ctrl;
  typedef logic [7:0] arr_t [8];
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, rdy_en = 1'b1, mdl_rdy = 1'b1;
  logic [7:0] in_data = '0, out_data, srt_datain, srt_dataout = '0;
  logic in_ready, out_valid, out_last, srt_start, srt_wr, srt_ready, done, err;
  logic [2:0] srt_addr;
  logic in_valid_b = 1'b0, srt_ready_b = 1'b1;
  logic [7:0] in_data_b = '0, out_data_b, srt_datain_b;
  logic in_ready_b, out_valid_b, out_last_b, srt_start_b, srt_wr_b, done_b, err_b;
  logic [2:0] srt_addr_b;
  logic [7:0] mem [8];
  int busy = 0;
  int total = 0, bad = 0;
  bit err_seen = 0;
  always #5 clk = ~clk;
  assign srt_ready = mdl_rdy & rdy_en;
  sort_stream_ctrl dut (
    .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .out_last(out_last),
    .srt_start(srt_start), .srt_wr(srt_wr), .srt_addr(srt_addr), .srt_datain(srt_datain),
    .srt_dataout(srt_dataout), .srt_ready(srt_ready), .done(done), .err(err)
  );
  sort_stream_ctrl #(.TIMEOUT(16)) dut_to (
    .clk(clk), .nrst(nrst), .in_valid(in_valid_b), .in_data(in_data_b), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(1'b1), .out_last(out_last_b),
    .srt_start(srt_start_b), .srt_wr(srt_wr_b), .srt_addr(srt_addr_b), .srt_datain(srt_datain_b),
    .srt_dataout(8'h00), .srt_ready(srt_ready_b), .done(done_b), .err(err_b)
  );
  always @(posedge clk) begin
    if (srt_wr) mem[srt_addr] = srt_datain;
    srt_dataout <= mem[srt_addr];
    if (srt_start) begin
      busy = 60;
      mdl_rdy <= 1'b0;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) begin
        for (int i = 0; i < 7; i++)
          for (int j = 0; j < 7 - i; j++)
            if (mem[j] > mem[j+1]) begin
              logic [7:0] t;
              t = mem[j];
              mem[j] = mem[j+1];
              mem[j+1] = t;
            end
        mdl_rdy <= 1'b1;
      end
    end
  end
  always @(negedge clk) if (err) err_seen = 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic load(input arr_t d);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data = d[i];
      #1;
      chk("ld_wr", srt_wr, 1);
      chk("ld_addr", srt_addr, i);
      chk("ld_din", srt_datain, d[i]);
      @(negedge clk);
    end
    #1;
    chk("kick", srt_start, 1);
    chk("kick_wr", srt_wr, 0);
    chk("kick_rdy", in_ready, 0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("kick_once", srt_start, 0);
  endtask
  task automatic drain(input arr_t e, input logic [3:0] pat);
    int n, k, w, prev, dn;
    logic [7:0] held;
    bit hold;
    n = 0; k = 0; w = 0; prev = -1; dn = 0; hold = 0; held = '0;
    while (!srt_ready && w < 300) begin
      @(negedge clk);
      w++;
    end
    chk("rdy_seen", srt_ready, 1);
    w = 0;
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("lat", w, 3);
    w = 0;
    while (n < 8 && w < 400) begin
      if (hold) begin
        chk("hold_v", out_valid, 1);
        chk("hold_d", out_data, held);
      end
      out_ready = pat[k%4];
      k++;
      #1;
      if (done) dn++;
      if (out_valid && out_ready) begin
        chk("dat", out_data, e[n]);
        chk("last", out_last, n == 7);
        if (pat == 4'b1111 && prev >= 0) chk("gap", w - prev, 3);
        prev = w;
        n++;
      end
      hold = out_valid && !out_ready;
      held = out_data;
      @(negedge clk);
      w++;
    end
    chk("n", n, 8);
    chk("done_early", dn, 0);
    #1;
    chk("done", done, 1);
    chk("ov_off", out_valid, 0);
    out_ready = 1'b0;
    @(negedge clk);
    chk("done_pulse", done, 0);
  endtask
  initial begin
    arr_t d1, s1, d2, s2;
    int n;
    bit ovb;
    d1 = '{8'h37, 8'h05, 8'hF0, 8'h12, 8'h05, 8'hA0, 8'h01, 8'h7E};
    s1 = '{8'h01, 8'h05, 8'h05, 8'h12, 8'h37, 8'h7E, 8'hA0, 8'hF0};
    d2 = '{8'h9C, 8'h03, 8'hFF, 8'h00, 8'h40, 8'h3F, 8'h81, 8'h7F};
    s2 = '{8'h00, 8'h03, 8'h3F, 8'h40, 8'h7F, 8'h81, 8'h9C, 8'hFF};
    @(negedge clk);
    chk("rst_start", srt_start, 0);
    chk("rst_wr", srt_wr, 0);
    chk("rst_addr", srt_addr, 0);
    chk("rst_din", srt_datain, 0);
    chk("rst_ov", out_valid, 0);
    chk("rst_od", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_irdy", in_ready, 1);
    nrst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      in_valid_b = 1'b1;
      in_data_b = 8'(i);
      @(negedge clk);
    end
    in_valid_b = 1'b0;
    chk("to_kick", srt_start_b, 1);
    srt_ready_b = 1'b0;
    n = 0;
    ovb = 0;
    while (!err_b && n < 40) begin
      @(negedge clk);
      n++;
      ovb |= out_valid_b;
    end
    chk("to_lat", n, 18);
    chk("to_ov", ovb, 0);
    @(negedge clk);
    chk("to_pulse", err_b, 0);
    chk("to_done", done_b, 0);
    srt_ready_b = 1'b1;
    #1;
    chk("to_load", in_ready_b, 1);
    @(negedge clk);
    rdy_en = 1'b0;
    in_valid = 1'b1;
    in_data = d1[0];
    #1;
    chk("stall_rdy", in_ready, 0);
    chk("stall_wr", srt_wr, 0);
    @(negedge clk);
    chk("stall_wr2", srt_wr, 0);
    rdy_en = 1'b1;
    load(d1);
    drain(s1, 4'b1111);
    load(d1);
    drain(s1, 4'b1001);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data = 8'h11 * 8'(i + 1);
      @(negedge clk);
    end
    chk("mid_addr", srt_addr, 5);
    nrst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("mid_rst_addr", srt_addr, 0);
    chk("mid_rst_ov", out_valid, 0);
    @(negedge clk);
    nrst = 1'b1;
    load(d2);
    drain(s2, 4'b1111);
    chk("no_err", err_seen, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
